// File: rtl/minisys_regfile_pkg.sv
// Shared constants for the minisys register file and its write-pending scoreboard.
package minisys_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/minisys_regfile_pending_cnt.sv
// Saturating up/down counter of outstanding writes for one register.
module minisys_pending_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic clrn,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic one,
  output logic max
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero = (cnt_q == '0);
  assign one  = (cnt_q == CNT_W'(1));
  assign max  = (cnt_q == '1);

  // Simultaneous inc/dec cancel; each direction saturates at its own bound.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !max)
      cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc && !zero)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clrn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/minisys_regfile.sv
// Register file with write-first bypass reads and a per-register write-pending scoreboard.
module minisys_regfile
  import minisys_pkg::*;
#(
  parameter int unsigned DATA_W = minisys_pkg::DATA_W,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  reg_writeW,
  input  logic [REG_ADDR_W-1:0] write_regD,
  input  logic [DATA_W-1:0]     result_to_writeW,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  output logic [DATA_W-1:0]     read_data1D,
  output logic [DATA_W-1:0]     read_data2D,
  input  logic                  issue_validD,
  input  logic [REG_ADDR_W-1:0] issue_regD,
  output logic                  rs_busyD,
  output logic                  rt_busyD,
  output logic                  issue_fullD,
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);
  logic [DATA_W-1:0] regs_q [NUM_REGS-1:1];

  logic                wb_en;
  logic [NUM_REGS-1:0] zero_v, one_v, max_v, inc_v, dec_v;

  assign wb_en = reg_writeW && (write_regD != REG_ZERO);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int unsigned i = 1; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[write_regD] <= result_to_writeW;
    end
  end

  function automatic logic [DATA_W-1:0] stored(input logic [REG_ADDR_W-1:0] a);
    return (a == REG_ZERO) ? '0 : regs_q[a];
  endfunction

  assign read_data1D = (wb_en && write_regD == rsD) ? result_to_writeW : stored(rsD);
  assign read_data2D = (wb_en && write_regD == rtD) ? result_to_writeW : stored(rtD);
  assign dbg_data    = stored(dbg_sel);

  // Register 0 has no counter: it reads as permanently idle and never full.
  assign zero_v[0] = 1'b1;
  assign one_v[0]  = 1'b0;
  assign max_v[0]  = 1'b0;

  assign issue_fullD = max_v[issue_regD] && !(wb_en && write_regD == issue_regD);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      inc_v[i] = issue_validD && !issue_fullD && (issue_regD == REG_ADDR_W'(i));
      dec_v[i] = wb_en && (write_regD == REG_ADDR_W'(i)) && !zero_v[i];
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    minisys_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .clrn (clrn),
      .inc  (inc_v[g]),
      .dec  (dec_v[g]),
      .zero (zero_v[g]),
      .one  (one_v[g]),
      .max  (max_v[g])
    );
  end

  // A write-back retiring the last outstanding write clears busy in the same cycle.
  assign rs_busyD = !zero_v[rsD] && !(dec_v[rsD] && one_v[rsD] && !inc_v[rsD]);
  assign rt_busyD = !zero_v[rtD] && !(dec_v[rtD] && one_v[rtD] && !inc_v[rtD]);
endmodule
